dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the pipeline MEM stage (CPU) and a debug/loader port (DBG).
- Decodes each granted request into the one-hot store/load strobes the data memory expects.
- Tracks the data memory's one-cycle registered read latency, so read data returns to the requester that issued it.
- CPU has priority. A starvation counter and a halt input guarantee that DBG makes forward progress.

---
 rtl/dmem_port_arbiter_if.sv | 57 +++++
 rtl/dmem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU requester, DBG requester and the shared memory side.
// The arbiter connects through the slave modport; requesters/memory model use master.
interface dmem_port_arbiter_if;
  // CPU (pipeline MEM stage) side
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  // Debug / loader side
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_halt;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  // Data memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_sw;
  logic        mem_sh;
  logic        mem_sb;
  logic        mem_lw;
  logic        mem_lh;
  logic        mem_lhu;
  logic        mem_lb;
  logic        mem_lbu;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_err, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_write, mem_sw, mem_sh, mem_sb,
    output mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_err, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_sw, mem_sh, mem_sb,
    input  mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU has priority, DBG is protected from starvation by a
// wait counter and can take the port outright with dbg_halt. Grants and memory
// strobes are combinational; a 2-bit return tag routes the one-cycle-late read data.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]         stat_conflicts,
  output logic [15:0]         stat_cpu_stalls,
  output logic [15:0]         stat_starve_wins
`endif
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic              cpu_ill;
  logic              cpu_valid;
  logic              cpu_win;
  logic              dbg_win;
  logic              starve_win;
  logic              cpu_stall;
  logic              dbg_gnt;

  logic [1:0]        rtag_q, rtag_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cpu_err_q, cpu_err_d;

  // An illegal size is dropped and does not compete for the port.
  assign cpu_ill   = bus.cpu_req & (bus.cpu_size == 2'b11);
  assign cpu_valid = bus.cpu_req & ~cpu_ill;

  // Winner selection: halt first, then lone requester, then starvation, then CPU.
  always_comb begin
    cpu_win    = 1'b0;
    dbg_win    = 1'b0;
    starve_win = 1'b0;
    if (bus.dbg_halt) begin
      dbg_win = bus.dbg_req;
    end else if (cpu_valid && bus.dbg_req) begin
      if (wait_cnt_q == MAX_CNT) begin
        dbg_win    = 1'b1;
        starve_win = 1'b1;
      end else begin
        cpu_win = 1'b1;
      end
    end else begin
      cpu_win = cpu_valid;
      dbg_win = bus.dbg_req;
    end
  end

  assign cpu_stall     = cpu_valid & ~cpu_win;
  assign dbg_gnt       = bus.dbg_req & dbg_win;
  assign bus.cpu_stall = cpu_stall;
  assign bus.dbg_gnt   = dbg_gnt;

  // Drive the memory port from the winner and decode the one-hot access strobe.
  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_write = 1'b0;
    bus.mem_sw    = 1'b0;
    bus.mem_sh    = 1'b0;
    bus.mem_sb    = 1'b0;
    bus.mem_lw    = 1'b0;
    bus.mem_lh    = 1'b0;
    bus.mem_lhu   = 1'b0;
    bus.mem_lb    = 1'b0;
    bus.mem_lbu   = 1'b0;
    if (cpu_win) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      if (bus.cpu_we) begin
        bus.mem_write = 1'b1;
        case (bus.cpu_size)
          2'b00:   bus.mem_sb = 1'b1;
          2'b01:   bus.mem_sh = 1'b1;
          default: bus.mem_sw = 1'b1;
        endcase
      end else begin
        case (bus.cpu_size)
          2'b00: begin
            bus.mem_lbu = bus.cpu_unsigned;
            bus.mem_lb  = ~bus.cpu_unsigned;
          end
          2'b01: begin
            bus.mem_lhu = bus.cpu_unsigned;
            bus.mem_lh  = ~bus.cpu_unsigned;
          end
          default: bus.mem_lw = 1'b1;
        endcase
      end
    end else if (dbg_win) begin
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
      if (bus.dbg_we) begin
        bus.mem_write = 1'b1;
        bus.mem_sw    = 1'b1;
      end else begin
        bus.mem_lw = 1'b1;
      end
    end
  end

  // Next state for return tag, starvation counter and error pulse.
  always_comb begin
    rtag_d    = {dbg_win & ~bus.dbg_we, cpu_win & ~bus.cpu_we};
    cpu_err_d = cpu_ill;
    if (!bus.dbg_req || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      rtag_q     <= 2'b00;
      wait_cnt_q <= '0;
      cpu_err_q  <= 1'b0;
    end else begin
      rtag_q     <= rtag_d;
      wait_cnt_q <= wait_cnt_d;
      cpu_err_q  <= cpu_err_d;
    end
  end

  assign bus.cpu_err    = cpu_err_q;
  assign bus.cpu_rvalid = rtag_q[0];
  assign bus.dbg_rvalid = rtag_q[1];
  assign bus.cpu_rdata  = rtag_q[0] ? bus.mem_rdata : 32'h0;
  assign bus.dbg_rdata  = rtag_q[1] ? bus.mem_rdata : 32'h0;

`ifdef DMEM_ARB_STATS_EN
  logic [2:0]  stat_inc;
  logic [15:0] stat_q [3];

  assign stat_inc[0] = bus.cpu_req & bus.dbg_req;
  assign stat_inc[1] = cpu_stall;
  assign stat_inc[2] = starve_win;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      // Saturating event counter.
      always_ff @(posedge clock) begin
        if (reset) begin
          stat_q[gi] <= 16'h0;
        end else if (stat_inc[gi] && stat_q[gi] != 16'hFFFF) begin
          stat_q[gi] <= stat_q[gi] + 16'h1;
        end
      end
    end
  endgenerate

  assign stat_conflicts   = stat_q[0];
  assign stat_cpu_stalls  = stat_q[1];
  assign stat_starve_wins = stat_q[2];
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter (default build, statistics disabled).
module tb_dmem_port_arbiter;

  localparam logic [8:0] ST_SW  = 9'h180;
  localparam logic [8:0] ST_SH  = 9'h140;
  localparam logic [8:0] ST_SB  = 9'h120;
  localparam logic [8:0] LD_LW  = 9'h010;
  localparam logic [8:0] LD_LH  = 9'h008;
  localparam logic [8:0] LD_LHU = 9'h004;
  localparam logic [8:0] LD_LB  = 9'h002;
  localparam logic [8:0] LD_LBU = 9'h001;

  logic clock;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  dmem_port_arbiter_if bus_if ();

  dmem_port_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  // {write, sw, sh, sb, lw, lh, lhu, lb, lbu}
  logic [8:0] strb;
  assign strb = {bus_if.mem_write, bus_if.mem_sw, bus_if.mem_sh, bus_if.mem_sb,
                 bus_if.mem_lw, bus_if.mem_lh, bus_if.mem_lhu, bus_if.mem_lb,
                 bus_if.mem_lbu};

  always #5 clock = ~clock;

  task automatic idle();
    bus_if.cpu_req      = 1'b0;
    bus_if.cpu_we       = 1'b0;
    bus_if.cpu_size     = 2'b00;
    bus_if.cpu_unsigned = 1'b0;
    bus_if.cpu_addr     = 32'h0;
    bus_if.cpu_wdata    = 32'h0;
    bus_if.dbg_req      = 1'b0;
    bus_if.dbg_we       = 1'b0;
    bus_if.dbg_addr     = 32'h0;
    bus_if.dbg_wdata    = 32'h0;
    bus_if.dbg_halt     = 1'b0;
    bus_if.mem_rdata    = 32'h0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_load(input logic [31:0] addr);
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_size = 2'b10;
    bus_if.cpu_addr = addr;
  endtask

  task automatic dbg_load(input logic [31:0] addr);
    bus_if.dbg_req  = 1'b1;
    bus_if.dbg_we   = 1'b0;
    bus_if.dbg_addr = addr;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({bus_if.cpu_rvalid, bus_if.dbg_rvalid, bus_if.cpu_err} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_flags got %b want 000",
               {bus_if.cpu_rvalid, bus_if.dbg_rvalid, bus_if.cpu_err});
    end
    vec_cnt++;
    if (strb !== 9'h0 || bus_if.mem_addr !== 32'h0 || bus_if.cpu_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle_port got strb=%h addr=%h stall=%b want 000/0/0",
               strb, bus_if.mem_addr, bus_if.cpu_stall);
    end
    $display("test_reset done");
  endtask

  task automatic test_cpu_load();
    cpu_load(32'h10);
    #1;
    vec_cnt++;
    if (strb !== LD_LW || bus_if.cpu_stall !== 1'b0 || bus_if.mem_addr !== 32'h10) begin
      err_cnt++;
      $display("FAIL cpu_load_issue got strb=%h stall=%b addr=%h want %h/0/00000010",
               strb, bus_if.cpu_stall, bus_if.mem_addr, LD_LW);
    end
    step();
    idle();
    bus_if.mem_rdata = 32'hDEADBEEF;
    #1;
    vec_cnt++;
    if (bus_if.cpu_rvalid !== 1'b1 || bus_if.cpu_rdata !== 32'hDEADBEEF ||
        bus_if.dbg_rvalid !== 1'b0 || bus_if.dbg_rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL cpu_load_return got cv=%b cd=%h dv=%b dd=%h want 1/deadbeef/0/0",
               bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.dbg_rvalid, bus_if.dbg_rdata);
    end
    step();
    vec_cnt++;
    if (bus_if.cpu_rvalid !== 1'b0 || bus_if.cpu_rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL cpu_rvalid_pulse got cv=%b cd=%h want 0/0",
               bus_if.cpu_rvalid, bus_if.cpu_rdata);
    end
    $display("test_cpu_load done");
  endtask

  task automatic test_store_contested();
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = 1'b1;
    bus_if.cpu_size  = 2'b00;
    bus_if.cpu_addr  = 32'h3;
    bus_if.cpu_wdata = 32'hAB;
    dbg_load(32'h40);
    #1;
    vec_cnt++;
    if (strb !== ST_SB || bus_if.mem_addr !== 32'h3 || bus_if.mem_wdata !== 32'hAB) begin
      err_cnt++;
      $display("FAIL store_sb got strb=%h addr=%h wdata=%h want %h/3/ab",
               strb, bus_if.mem_addr, bus_if.mem_wdata, ST_SB);
    end
    vec_cnt++;
    if (bus_if.dbg_gnt !== 1'b0 || bus_if.cpu_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL store_grant got gnt=%b stall=%b want 0/0",
               bus_if.dbg_gnt, bus_if.cpu_stall);
    end
    step();
    idle();
    #1;
    vec_cnt++;
    if (dut.wait_cnt_q !== 3'd1 || bus_if.cpu_rvalid !== 1'b0 || bus_if.dbg_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL store_after got wait=%0d cv=%b dv=%b want 1/0/0",
               dut.wait_cnt_q, bus_if.cpu_rvalid, bus_if.dbg_rvalid);
    end
    step();
    $display("test_store_contested done");
  endtask

  task automatic test_starvation();
    logic prev_cpu;
    logic prev_dbg;
    logic exp_dbg;
    prev_cpu = 1'b0;
    prev_dbg = 1'b0;
    cpu_load(32'h100);
    dbg_load(32'h200);
    for (int i = 1; i <= 6; i++) begin
      #1;
      exp_dbg = (i == 5);
      vec_cnt++;
      if (bus_if.cpu_stall !== exp_dbg || bus_if.dbg_gnt !== exp_dbg ||
          bus_if.mem_addr !== (exp_dbg ? 32'h200 : 32'h100)) begin
        err_cnt++;
        $display("FAIL starve_cycle%0d got stall=%b gnt=%b addr=%h want %b/%b/%h", i,
                 bus_if.cpu_stall, bus_if.dbg_gnt, bus_if.mem_addr, exp_dbg, exp_dbg,
                 exp_dbg ? 32'h200 : 32'h100);
      end
      vec_cnt++;
      if (bus_if.cpu_rvalid !== prev_cpu || bus_if.dbg_rvalid !== prev_dbg) begin
        err_cnt++;
        $display("FAIL starve_rvalid%0d got cv=%b dv=%b want %b/%b", i,
                 bus_if.cpu_rvalid, bus_if.dbg_rvalid, prev_cpu, prev_dbg);
      end
      prev_cpu = ~exp_dbg;
      prev_dbg = exp_dbg;
      step();
    end
    idle();
    step();
    $display("test_starvation done");
  endtask

  task automatic test_halt();
    cpu_load(32'h100);
    bus_if.dbg_req   = 1'b1;
    bus_if.dbg_we    = 1'b1;
    bus_if.dbg_addr  = 32'h80;
    bus_if.dbg_wdata = 32'h12345678;
    bus_if.dbg_halt  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      vec_cnt++;
      if (bus_if.dbg_gnt !== 1'b1 || bus_if.cpu_stall !== 1'b1 || strb !== ST_SW ||
          bus_if.mem_addr !== 32'h80 || bus_if.mem_wdata !== 32'h12345678) begin
        err_cnt++;
        $display("FAIL halt_cycle%0d got gnt=%b stall=%b strb=%h addr=%h wd=%h want 1/1/%h/80/12345678",
                 i, bus_if.dbg_gnt, bus_if.cpu_stall, strb, bus_if.mem_addr,
                 bus_if.mem_wdata, ST_SW);
      end
      step();
    end
    idle();
    step();
    $display("test_halt done");
  endtask

  task automatic test_back_to_back();
    cpu_load(32'h20);
    #1;
    vec_cnt++;
    if (strb !== LD_LW || bus_if.mem_addr !== 32'h20) begin
      err_cnt++;
      $display("FAIL b2b_cpu_issue got strb=%h addr=%h want %h/20", strb, bus_if.mem_addr, LD_LW);
    end
    step();
    idle();
    dbg_load(32'h24);
    bus_if.mem_rdata = 32'h11111111;
    #1;
    vec_cnt++;
    if (bus_if.cpu_rvalid !== 1'b1 || bus_if.cpu_rdata !== 32'h11111111 ||
        bus_if.dbg_rvalid !== 1'b0 || bus_if.dbg_rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL b2b_cpu_ret got cv=%b cd=%h dv=%b dd=%h want 1/11111111/0/0",
               bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.dbg_rvalid, bus_if.dbg_rdata);
    end
    vec_cnt++;
    if (bus_if.dbg_gnt !== 1'b1 || strb !== LD_LW || bus_if.mem_addr !== 32'h24) begin
      err_cnt++;
      $display("FAIL b2b_dbg_issue got gnt=%b strb=%h addr=%h want 1/%h/24",
               bus_if.dbg_gnt, strb, bus_if.mem_addr, LD_LW);
    end
    step();
    idle();
    bus_if.mem_rdata = 32'h22222222;
    #1;
    vec_cnt++;
    if (bus_if.dbg_rvalid !== 1'b1 || bus_if.dbg_rdata !== 32'h22222222 ||
        bus_if.cpu_rvalid !== 1'b0 || bus_if.cpu_rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL b2b_dbg_ret got dv=%b dd=%h cv=%b cd=%h want 1/22222222/0/0",
               bus_if.dbg_rvalid, bus_if.dbg_rdata, bus_if.cpu_rvalid, bus_if.cpu_rdata);
    end
    step();
    vec_cnt++;
    if (bus_if.dbg_rvalid !== 1'b0 || bus_if.cpu_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_quiet got dv=%b cv=%b want 0/0", bus_if.dbg_rvalid, bus_if.cpu_rvalid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_size_decode();
    logic       we_tab  [8];
    logic [1:0] sz_tab  [8];
    logic       uns_tab [8];
    logic [8:0] exp_tab [8];
    we_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sz_tab  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    uns_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_tab = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, ST_SB, ST_SH, ST_SW};
    for (int i = 0; i < 8; i++) begin
      bus_if.cpu_req      = 1'b1;
      bus_if.cpu_we       = we_tab[i];
      bus_if.cpu_size     = sz_tab[i];
      bus_if.cpu_unsigned = uns_tab[i];
      bus_if.cpu_addr     = 32'h500 + 32'(i);
      #1;
      vec_cnt++;
      if (strb !== exp_tab[i]) begin
        err_cnt++;
        $display("FAIL decode%0d got strb=%h want %h", i, strb, exp_tab[i]);
      end
      step();
    end
    idle();
    step();
    $display("test_size_decode done");
  endtask

  task automatic test_illegal();
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_size = 2'b11;
    bus_if.cpu_addr = 32'h60;
    #1;
    vec_cnt++;
    if (strb !== 9'h0 || bus_if.cpu_stall !== 1'b0 || bus_if.mem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL illegal_alone got strb=%h stall=%b addr=%h want 0/0/0",
               strb, bus_if.cpu_stall, bus_if.mem_addr);
    end
    step();
    dbg_load(32'h30);
    #1;
    vec_cnt++;
    if (bus_if.cpu_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL illegal_err got %b want 1", bus_if.cpu_err);
    end
    vec_cnt++;
    if (bus_if.dbg_gnt !== 1'b1 || strb !== LD_LW || bus_if.cpu_stall !== 1'b0 ||
        bus_if.mem_addr !== 32'h30) begin
      err_cnt++;
      $display("FAIL illegal_dbg_use got gnt=%b strb=%h stall=%b addr=%h want 1/%h/0/30",
               bus_if.dbg_gnt, strb, bus_if.cpu_stall, bus_if.mem_addr, LD_LW);
    end
    step();
    idle();
    bus_if.mem_rdata = 32'h0BADF00D;
    #1;
    vec_cnt++;
    if (bus_if.dbg_rvalid !== 1'b1 || bus_if.dbg_rdata !== 32'h0BADF00D ||
        bus_if.cpu_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL illegal_dbg_ret got dv=%b dd=%h cv=%b want 1/0badf00d/0",
               bus_if.dbg_rvalid, bus_if.dbg_rdata, bus_if.cpu_rvalid);
    end
    step();
    vec_cnt++;
    if (bus_if.cpu_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL illegal_err_pulse got %b want 0", bus_if.cpu_err);
    end
    $display("test_illegal done");
  endtask

  task automatic test_reset_inflight();
    cpu_load(32'h100);
    dbg_load(32'h200);
    step();
    step();
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (strb !== LD_LW || bus_if.mem_addr !== 32'h100) begin
      err_cnt++;
      $display("FAIL reset_comb got strb=%h addr=%h want %h/100", strb, bus_if.mem_addr, LD_LW);
    end
    step();
    reset = 1'b0;
    idle();
    bus_if.mem_rdata = 32'hCAFEF00D;
    #1;
    vec_cnt++;
    if (bus_if.cpu_rvalid !== 1'b0 || bus_if.dbg_rvalid !== 1'b0 ||
        bus_if.cpu_rdata !== 32'h0 || dut.wait_cnt_q !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_inflight got cv=%b dv=%b cd=%h wait=%0d want 0/0/0/0",
               bus_if.cpu_rvalid, bus_if.dbg_rvalid, bus_if.cpu_rdata, dut.wait_cnt_q);
    end
    step();
    $display("test_reset_inflight done");
  endtask

  initial begin
    clock   = 1'b0;
    reset   = 1'b1;
    vec_cnt = 0;
    err_cnt = 0;
    idle();
    test_reset();
    test_cpu_load();
    test_store_contested();
    test_starvation();
    test_halt();
    test_back_to_back();
    test_size_decode();
    test_illegal();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
